// File: rtl/cash_dispenser.sv
// Cash dispenser: plans a withdrawal greedily over four note stocks (20, 10, 5, 1),
// then ejects one note per cycle, largest denomination first.
// Optional audit counters (total_out, fail_cnt) are built when CASH_AUDIT_EN is defined.
module cash_dispenser (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [5:0] amount,
   input  logic       refill,
   input  logic [1:0] refill_denom,
   input  logic [7:0] refill_count,
   output logic       busy,
   output logic       note_valid,
   output logic [1:0] note_denom,
   output logic       done,
   output logic       fail
`ifdef CASH_AUDIT_EN
   ,
   output logic [15:0] total_out,
   output logic [7:0]  fail_cnt
`endif
);

   typedef enum logic [2:0] {StIdle, StPlan, StDispense, StDone, StFail} state_e;

   state_e          state_q;
   logic [3:0][7:0] stock_q;   // index 0 = 20, 1 = 10, 2 = 5, 3 = 1
   logic [3:0][5:0] plan_q;
   logic [5:0]      rem_q;
   logic [1:0]      idx_q;

   // Plan-step datapath
   logic [5:0] denom_v;
   logic [5:0] quot;
   logic [7:0] stk;
   logic [5:0] plan_n;
   logic [5:0] prod;
   logic [5:0] rem_nx;
   logic       plan_any;

   // Dispense-step datapath
   logic [1:0] sel;
   logic [7:0] notes_left;
   logic       last_note;

   // Refill datapath
   logic [8:0] refill_sum;

   function automatic logic [5:0] denom_val(input logic [1:0] i);
      unique case (i)
         2'd0:    denom_val = 6'd20;
         2'd1:    denom_val = 6'd10;
         2'd2:    denom_val = 6'd5;
         default: denom_val = 6'd1;
      endcase
   endfunction

   // One greedy planning step for the denomination selected by idx_q
   always_comb begin
      denom_v = denom_val(idx_q);
      unique case (idx_q)
         2'd0:    quot = rem_q / 6'd20;
         2'd1:    quot = rem_q / 6'd10;
         2'd2:    quot = rem_q / 6'd5;
         default: quot = rem_q;
      endcase
      stk    = stock_q[idx_q];
      plan_n = (stk < {2'b00, quot}) ? stk[5:0] : quot;
      // plan_n * denom never exceeds rem_q, so 6 bits are enough
      prod   = plan_n * denom_v;
      rem_nx = rem_q - prod;
      plan_any = (plan_q[0] != 6'd0) || (plan_q[1] != 6'd0) ||
                 (plan_q[2] != 6'd0) || (plan_n != 6'd0);
   end

   // Pick the largest denomination still owed and detect the final note
   always_comb begin
      if (plan_q[0] != 6'd0)      sel = 2'd0;
      else if (plan_q[1] != 6'd0) sel = 2'd1;
      else if (plan_q[2] != 6'd0) sel = 2'd2;
      else                        sel = 2'd3;
      notes_left = {2'b00, plan_q[0]} + {2'b00, plan_q[1]} +
                   {2'b00, plan_q[2]} + {2'b00, plan_q[3]};
      last_note  = (notes_left == 8'd1);
   end

   // Saturating refill sum for the selected stock
   always_comb begin
      refill_sum = {1'b0, stock_q[refill_denom]} + {1'b0, refill_count};
   end

   assign busy = (state_q != StIdle);

   // Main FSM with stocks, plan counters and registered output pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         stock_q    <= '0;
         plan_q     <= '0;
         rem_q      <= '0;
         idx_q      <= '0;
         note_valid <= 1'b0;
         note_denom <= 2'd0;
         done       <= 1'b0;
         fail       <= 1'b0;
`ifdef CASH_AUDIT_EN
         total_out  <= '0;
         fail_cnt   <= '0;
`endif
      end else begin
         note_valid <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  rem_q   <= amount;
                  plan_q  <= '0;
                  idx_q   <= 2'd0;
                  state_q <= StPlan;
               end else if (refill) begin
                  stock_q[refill_denom] <= refill_sum[8] ? 8'hff : refill_sum[7:0];
               end
            end
            StPlan: begin
               plan_q[idx_q] <= plan_n;
               rem_q         <= rem_nx;
               idx_q         <= idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  if (rem_nx != 6'd0) state_q <= StFail;
                  else if (!plan_any) state_q <= StDone;
                  else                state_q <= StDispense;
               end
            end
            StDispense: begin
               note_valid   <= 1'b1;
               note_denom   <= sel;
               plan_q[sel]  <= plan_q[sel] - 6'd1;
               stock_q[sel] <= stock_q[sel] - 8'd1;
`ifdef CASH_AUDIT_EN
               total_out    <= total_out + {10'd0, denom_val(sel)};
`endif
               if (last_note) state_q <= StDone;
            end
            StDone: begin
               done    <= 1'b1;
               state_q <= StIdle;
            end
            StFail: begin
               fail    <= 1'b1;
`ifdef CASH_AUDIT_EN
               if (fail_cnt != 8'hff) fail_cnt <= fail_cnt + 8'd1;
`endif
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cash_dispenser.sv
// Self-checking bench for cash_dispenser: table of withdrawal scenarios plus
// hand-written sequences for held req, refill saturation/priority and mid-dispense reset.
module tb_cash_dispenser;

   logic       clk = 1'b0;
   logic       rst, req, refill;
   logic [5:0] amount;
   logic [1:0] refill_denom;
   logic [7:0] refill_count;
   logic       busy, note_valid, done, fail;
   logic [1:0] note_denom;
`ifdef CASH_AUDIT_EN
   logic [15:0] total_out;
   logic [7:0]  fail_cnt;
`endif

   cash_dispenser dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .amount       (amount),
      .refill       (refill),
      .refill_denom (refill_denom),
      .refill_count (refill_count),
      .busy         (busy),
      .note_valid   (note_valid),
      .note_denom   (note_denom),
      .done         (done),
      .fail         (fail)
`ifdef CASH_AUDIT_EN
      ,
      .total_out    (total_out),
      .fail_cnt     (fail_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          fill[4];   // notes refilled per denom index (0=20,1=10,2=5,3=1)
      int          amt;
      int          n;         // expected number of notes
      logic [31:0] notes;     // expected denoms, one hex digit each, first note leftmost
      int          exp_fail;
      int          stk[4];    // expected stocks afterwards
   } vec_t;

   vec_t vecs[7];
   int   passed = 0;
   int   total  = 0;

   int got_n, done_cyc, fail_cyc, busy_e0;
   int got_d[16];
   int got_c[16];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 1'b0; refill = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic do_refill(input int d, input int c);
      refill = 1'b1; refill_denom = 2'(d); refill_count = 8'(c);
      tick();
      refill = 1'b0;
   endtask

   // Issue one request, then record notes/done/fail with cycle index relative to the sampling edge
   task automatic run_req(input int amt);
      got_n = 0; done_cyc = -1; fail_cyc = -1;
      req = 1'b1; amount = 6'(amt);
      tick();
      req = 1'b0;
      busy_e0 = int'(busy);
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (note_valid) begin
            if (got_n < 16) begin
               got_d[got_n] = int'(note_denom);
               got_c[got_n] = c;
            end
            got_n++;
         end
         if (done) done_cyc = c;
         if (fail) fail_cyc = c;
         if (done || fail) break;
      end
   endtask

   function automatic vec_t mk(input int f20, input int f10, input int f5, input int f1,
                               input int amt, input int n, input logic [31:0] notes,
                               input int ef, input int s20, input int s10, input int s5,
                               input int s1);
      vec_t v;
      v.fill[0] = f20; v.fill[1] = f10; v.fill[2] = f5; v.fill[3] = f1;
      v.amt = amt; v.n = n; v.notes = notes; v.exp_fail = ef;
      v.stk[0] = s20; v.stk[1] = s10; v.stk[2] = s5; v.stk[3] = s1;
      return v;
   endfunction

   initial begin
      int exp_val, dones, fails, notes;
      rst = 1'b1; req = 1'b0; refill = 1'b0; amount = '0;
      refill_denom = '0; refill_count = '0;

      //     20  10  5   1  amt n  notes      fail stocks after
      vecs[0] = mk(0,  0,  0,  0,  5, 0, 32'h0,     1, 0, 0, 0, 0);
      vecs[1] = mk(2,  0,  0,  3, 43, 5, 32'h00333, 0, 0, 0, 0, 0);
      vecs[2] = mk(10, 10, 10, 10, 37, 5, 32'h01233, 0, 9, 9, 9, 8);
      vecs[3] = mk(10, 10, 10, 10,  0, 0, 32'h0,     0, 10, 10, 10, 10);
      vecs[4] = mk(1,  1,  1,  0, 36, 0, 32'h0,     1, 1, 1, 1, 0);
      vecs[5] = mk(0,  3,  2,  0, 40, 5, 32'h11122, 0, 0, 0, 0, 0);
      vecs[6] = mk(5,  0,  0, 10, 63, 6, 32'h000333, 0, 2, 0, 0, 7);

      // Reset state
      do_reset();
      check("reset busy", int'(busy), 0);
      check("reset note_valid", int'(note_valid), 0);
      check("reset done", int'(done), 0);
      check("reset fail", int'(fail), 0);
      check("reset note_denom", int'(note_denom), 0);
      for (int i = 0; i < 4; i++) check($sformatf("reset stock%0d", i), int'(dut.stock_q[i]), 0);

      // Table-driven withdrawals
      for (int k = 0; k < 7; k++) begin
         do_reset();
         for (int i = 0; i < 4; i++) if (vecs[k].fill[i] != 0) do_refill(i, vecs[k].fill[i]);
         run_req(vecs[k].amt);
         check($sformatf("v%0d busy after req", k), busy_e0, 1);
         if (vecs[k].exp_fail != 0) begin
            check($sformatf("v%0d fail cycle", k), fail_cyc, 5);
            check($sformatf("v%0d done absent", k), done_cyc, -1);
         end else begin
            check($sformatf("v%0d done cycle", k), done_cyc, 5 + vecs[k].n);
            check($sformatf("v%0d fail absent", k), fail_cyc, -1);
         end
         check($sformatf("v%0d note count", k), got_n, vecs[k].n);
         exp_val = 0;
         for (int i = 0; i < vecs[k].n && i < got_n; i++) begin
            int ed;
            ed = int'((vecs[k].notes >> ((vecs[k].n - 1 - i) * 4)) & 32'hf);
            exp_val += (ed == 0) ? 20 : (ed == 1) ? 10 : (ed == 2) ? 5 : 1;
            check($sformatf("v%0d note%0d denom", k, i), got_d[i], ed);
            check($sformatf("v%0d note%0d cycle", k, i), got_c[i], 5 + i);
         end
         for (int i = 0; i < 4; i++)
            check($sformatf("v%0d stock%0d", k, i), int'(dut.stock_q[i]), vecs[k].stk[i]);
`ifdef CASH_AUDIT_EN
         check($sformatf("v%0d total_out", k), int'(total_out), exp_val);
         check($sformatf("v%0d fail_cnt", k), int'(fail_cnt), vecs[k].exp_fail);
`endif
      end

      // req held high while busy: only one request accepted
      do_reset();
      for (int i = 0; i < 4; i++) do_refill(i, 10);
      req = 1'b1; amount = 6'd0;
      tick();
      check("held req busy", int'(busy), 1);
      tick(); tick();
      req = 1'b0;
      dones = 0; fails = 0; notes = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         dones += int'(done); fails += int'(fail); notes += int'(note_valid);
      end
      check("held req done pulses", dones, 1);
      check("held req fail pulses", fails, 0);
      check("held req notes", notes, 0);
      check("held req idle", int'(busy), 0);

      // Refill saturation, then refill and req together (req wins, refill dropped)
      do_reset();
      do_refill(3, 250);
      check("stock1 at 250", int'(dut.stock_q[3]), 250);
      do_refill(3, 10);
      check("stock1 saturates", int'(dut.stock_q[3]), 255);
      refill = 1'b1; refill_denom = 2'd3; refill_count = 8'd5;
      req = 1'b1; amount = 6'd1;
      tick();
      refill = 1'b0; req = 1'b0;
      check("req over refill stock", int'(dut.stock_q[3]), 255);
      check("req over refill busy", int'(busy), 1);
      dones = 0; notes = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         dones += int'(done); notes += int'(note_valid);
      end
      check("req over refill done", dones, 1);
      check("req over refill notes", notes, 1);
      check("req over refill stock after", int'(dut.stock_q[3]), 254);

      // Reset in the middle of dispensing 20,20,10,10
      do_reset();
      do_refill(0, 2);
      do_refill(1, 2);
      req = 1'b1; amount = 6'd60;
      tick();
      req = 1'b0;
      notes = 0;
      for (int c = 0; c < 20 && notes < 2; c++) begin
         tick();
         notes += int'(note_valid);
      end
      check("mid-dispense notes before rst", notes, 2);
      check("mid-dispense stock20 before rst", int'(dut.stock_q[0]), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst abort busy", int'(busy), 0);
      check("rst abort note_valid", int'(note_valid), 0);
      check("rst abort done", int'(done), 0);
      for (int i = 0; i < 4; i++) check($sformatf("rst abort stock%0d", i), int'(dut.stock_q[i]), 0);
`ifdef CASH_AUDIT_EN
      check("rst abort total_out", int'(total_out), 0);
      check("rst abort fail_cnt", int'(fail_cnt), 0);
`endif
      dones = 0; notes = 0; fails = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         dones += int'(done); notes += int'(note_valid); fails += int'(fail);
      end
      check("after abort done", dones, 0);
      check("after abort notes", notes, 0);
      check("after abort fail", fails, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
